pause_ctrl: RTL and testbench
=============================

PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYC, default 2, range 1..15: total stall cycles per instruction-RAM data access from MEM.
REQ-002 The block SHALL have port clk_50MHz  in  1  single clock, all state rising-edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port id_REGA_ADDR  in  4  source register A of instruction in ID.
REQ-005 The block SHALL have port id_REGA_use  in  1  ID instruction reads A.
REQ-006 The block SHALL have port id_REGB_ADDR  in  4  source register B of instruction in ID.
REQ-007 The block SHALL have port id_REGB_use  in  1  ID instruction reads B.
REQ-008 The block SHALL have port ie_WB_en  in  1  EXE instruction writes a register.
REQ-009 The block SHALL have port ie_WB_ADDR  in  4  EXE destination register.
REQ-010 The block SHALL have port ie_RAM_en  in  1  EXE instruction accesses RAM.
REQ-011 The block SHALL have port ie_RAM_op  in  1  EXE RAM direction, `RAM_OP_RD = load.
REQ-012 The block SHALL have port mem_WB_en  in  1  MEM instruction writes a register.
REQ-013 The block SHALL have port mem_WB_ADDR  in  4  MEM destination register.
REQ-014 The block SHALL have port mem_RAM_en  in  1  MEM instruction accesses RAM.
REQ-015 The block SHALL have port mem_RAM_ADDR  in  16  MEM RAM address; < 16'h8000 = instruction RAM.
REQ-016 The block SHALL have port jump_en  in  1  taken jump resolved in EXE.
REQ-017 The block SHALL have port pc_PAUSE  out  1  hold PC.
REQ-018 The block SHALL have port if_PAUSE  out  1  hold IF/ID register.
REQ-019 The block SHALL have port if_FLUSH  out  1  load NOP into IF/ID.
REQ-020 The block SHALL have port ie_PAUSE  out  1  hold ID/EXE register.
REQ-021 The block SHALL have port jump_control_ie_PAUSE  out  1  load bubble (all ops NOP) into ID/EXE.
REQ-022 The block SHALL have port em_PAUSE  out  1  hold EXE/MEM register.

Function
REQ-023 The block SHALL implement FSM states RUN and WAIT plus 4-bit down-counter cnt; all outputs SHALL be combinational from state, cnt and inputs, active = `PAUSE_ENABLE.
REQ-024 The block SHALL define struct hit = mem_RAM_en & mem_RAM_ADDR < 16'h8000.
REQ-025 The block SHALL drive the hold pattern as pc_PAUSE, if_PAUSE, ie_PAUSE, em_PAUSE = 1, others 0.
REQ-026 The block SHALL drive the final pattern as pc_PAUSE = ~jump_en, if_FLUSH = 1, jump_control_ie_PAUSE = jump_en, others 0.
REQ-027 In RUN with struct hit, the block SHALL: if WAIT_CYC = 1 drive final pattern and stay in RUN; else drive hold pattern, go to WAIT, cnt <= WAIT_CYC-2.
REQ-028 In WAIT, the block SHALL: if cnt = 0 drive final pattern and go to RUN; else drive hold pattern and cnt <= cnt-1; inputs other than jump_en SHALL be ignored in WAIT.
REQ-029 In RUN without struct hit and with jump_en, the block SHALL drive if_FLUSH = 1 and jump_control_ie_PAUSE = 1, PC not paused.
REQ-030 In RUN without struct hit, without jump_en and with data hazard, the block SHALL drive pc_PAUSE, if_PAUSE, jump_control_ie_PAUSE = 1.
REQ-031 The block SHALL detect a data hazard as ie_RAM_en & ie_RAM_op = `RAM_OP_RD & ie_WB_en, with (id_REGA_use & A = ie_WB_ADDR) or (id_REGB_use & B = ie_WB_ADDR).
REQ-032 The block SHALL apply fixed priority struct > jump > data hazard; if none is active, all outputs SHALL be 0.
REQ-033 The block SHALL NOT assert if_PAUSE and if_FLUSH in the same cycle.

Reset
REQ-034 While rst = 0 the block SHALL force state RUN, cnt 0 and all outputs 0; reset mid-WAIT SHALL abandon the stall immediately.

Configuration
REQ-035 The block SHALL use macro PAUSE_CTRL_FWD_EN: when defined, data hazard = load-use only (REQ-031); when undefined, data hazard = any ID read matching ie_WB_ADDR (ie_WB_en) or mem_WB_ADDR (mem_WB_en), with no RAM qualifier.

Structure
REQ-036 `PAUSE_ENABLE, `RAM_OP_RD, the IRAM boundary constant and the state encodings SHALL live in define.v; the block SHALL have no sub-modules.

Verification
REQ-037 The bench SHALL cover load-use: ie load to R3, ID reads R3 via A -> one cycle of pc_PAUSE=if_PAUSE=jump_control_ie_PAUSE=1, then all 0.
REQ-038 The bench SHALL cover WAIT_CYC=3 with mem_RAM_ADDR=16'h4000 -> 2 hold-pattern cycles then 1 final cycle (pc_PAUSE=1, if_FLUSH=1), then RUN.
REQ-039 The bench SHALL cover jump_en held during a WAIT_CYC=2 stall -> hold, then final with pc_PAUSE=0 and jump_control_ie_PAUSE=1.
REQ-040 The bench SHALL cover mem_RAM_ADDR=16'h8000 -> no stall; jump_en alone -> if_FLUSH=jump_control_ie_PAUSE=1 for one cycle.
REQ-041 The bench SHALL cover rst low mid-WAIT -> all outputs 0 immediately; after release, state is RUN.
REQ-042 The bench SHALL cover the case with PAUSE_CTRL_FWD_EN undefined, ALU op in EXE writing R5 and ID reading R5 via B -> stall; with the macro defined -> no stall.

Source files
------------

// File: rtl/pause_ctrl_pkg.sv
// Shared constants, state encoding and pause-pattern helpers for pause_ctrl.
// Optional build macro PAUSE_CTRL_FWD_EN selects load-use-only hazard detection.
package pause_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned ADDR_W  = 16;

  localparam logic              PAUSE_ENABLE = 1'b1;
  localparam logic              RAM_OP_RD    = 1'b0;
  localparam logic [ADDR_W-1:0] IRAM_LIMIT   = 16'h8000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc;
    logic if_p;
    logic if_f;
    logic ie_p;
    logic jc_ie;
    logic em;
  } pause_t;

  function automatic pause_t idle_pattern();
    pause_t p;
    p = '{default: ~PAUSE_ENABLE};
    return p;
  endfunction

  // Freeze every stage up to EXE/MEM while the instruction RAM serves MEM.
  function automatic pause_t hold_pattern();
    pause_t p;
    p      = idle_pattern();
    p.pc   = PAUSE_ENABLE;
    p.if_p = PAUSE_ENABLE;
    p.ie_p = PAUSE_ENABLE;
    p.em   = PAUSE_ENABLE;
    return p;
  endfunction

  // Last stall cycle: the fetched word is stale, so flush IF/ID; a taken jump lets the PC move.
  function automatic pause_t final_pattern(input logic jump);
    pause_t p;
    p       = idle_pattern();
    p.pc    = jump ? ~PAUSE_ENABLE : PAUSE_ENABLE;
    p.if_f  = PAUSE_ENABLE;
    p.jc_ie = jump ? PAUSE_ENABLE : ~PAUSE_ENABLE;
    return p;
  endfunction

  function automatic pause_t jump_pattern();
    pause_t p;
    p       = idle_pattern();
    p.if_f  = PAUSE_ENABLE;
    p.jc_ie = PAUSE_ENABLE;
    return p;
  endfunction

  function automatic pause_t hazard_pattern();
    pause_t p;
    p       = idle_pattern();
    p.pc    = PAUSE_ENABLE;
    p.if_p  = PAUSE_ENABLE;
    p.jc_ie = PAUSE_ENABLE;
    return p;
  endfunction

endpackage

// File: rtl/pause_ctrl.sv
// Pipeline stall/flush controller: IRAM structural stall, taken jumps and data hazards.
// Build macro PAUSE_CTRL_FWD_EN: defined = load-use hazards only; undefined = any RAW on EXE/MEM.
module pause_ctrl
  import pause_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_REGA_ADDR,
  input  logic              id_REGA_use,
  input  logic [REG_W-1:0]  id_REGB_ADDR,
  input  logic              id_REGB_use,
  input  logic              ie_WB_en,
  input  logic [REG_W-1:0]  ie_WB_ADDR,
  input  logic              ie_RAM_en,
  input  logic              ie_RAM_op,
  input  logic              mem_WB_en,
  input  logic [REG_W-1:0]  mem_WB_ADDR,
  input  logic              mem_RAM_en,
  input  logic [ADDR_W-1:0] mem_RAM_ADDR,
  input  logic              jump_en,
  output logic              pc_PAUSE,
  output logic              if_PAUSE,
  output logic              if_FLUSH,
  output logic              ie_PAUSE,
  output logic              jump_control_ie_PAUSE,
  output logic              em_PAUSE
);

  localparam int unsigned       CNT_INIT_I = (WAIT_CYC >= 2) ? (WAIT_CYC - 2) : 0;
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(CNT_INIT_I);
  localparam bit                SINGLE_CYC = (WAIT_CYC == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pause_t           pause_c;
  logic             struct_hit_c;
  logic             data_hazard_c;
  logic             unused_inputs;

  assign struct_hit_c = mem_RAM_en & (mem_RAM_ADDR < IRAM_LIMIT);

`ifdef PAUSE_CTRL_FWD_EN
  // Forwarding covers ALU results; only a load in EXE still has no data for ID.
  assign data_hazard_c = ie_RAM_en & (ie_RAM_op == RAM_OP_RD) & ie_WB_en &
                         ((id_REGA_use & (id_REGA_ADDR == ie_WB_ADDR)) |
                          (id_REGB_use & (id_REGB_ADDR == ie_WB_ADDR)));
  assign unused_inputs = ^{mem_WB_en, mem_WB_ADDR};
`else
  assign data_hazard_c = (ie_WB_en &
                          ((id_REGA_use & (id_REGA_ADDR == ie_WB_ADDR)) |
                           (id_REGB_use & (id_REGB_ADDR == ie_WB_ADDR)))) |
                         (mem_WB_en &
                          ((id_REGA_use & (id_REGA_ADDR == mem_WB_ADDR)) |
                           (id_REGB_use & (id_REGB_ADDR == mem_WB_ADDR))));
  assign unused_inputs = ^{ie_RAM_en, ie_RAM_op};
`endif

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pause pattern; priority is structural > jump > data hazard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pause_c = idle_pattern();
    case (state_q)
      ST_RUN: begin
        if (struct_hit_c) begin
          if (SINGLE_CYC) begin
            pause_c = final_pattern(jump_en);
          end else begin
            pause_c = hold_pattern();
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (jump_en) begin
          pause_c = jump_pattern();
        end else if (data_hazard_c) begin
          pause_c = hazard_pattern();
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          pause_c = final_pattern(jump_en);
          state_d = ST_RUN;
        end else begin
          pause_c = hold_pattern();
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst) begin
      pause_c = idle_pattern();
    end
  end

  assign pc_PAUSE              = pause_c.pc;
  assign if_PAUSE              = pause_c.if_p;
  assign if_FLUSH              = pause_c.if_f;
  assign ie_PAUSE              = pause_c.ie_p;
  assign jump_control_ie_PAUSE = pause_c.jc_ie;
  assign em_PAUSE              = pause_c.em;

endmodule

// File: tb/tb_pause_ctrl.sv
// Scoreboard bench for pause_ctrl: WAIT_CYC=2 and WAIT_CYC=3 instances share stimulus.
// Honours PAUSE_CTRL_FWD_EN when deciding whether a plain ALU RAW must stall.
module tb_pause_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_a, id_b, ie_wb_addr, mem_wb_addr;
  logic        id_a_use, id_b_use, ie_wb_en, ie_ram_en, ie_ram_op;
  logic        mem_wb_en, mem_ram_en, jump_en;
  logic [15:0] mem_ram_addr;

  logic pc2, ifp2, iff2, iep2, jc2, em2;
  logic pc3, ifp3, iff3, iep3, jc3, em3;

  typedef struct {
    logic [5:0] exp;
    bit         dut3;
    string      name;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] HOLD = 6'b110101;
  localparam logic [5:0] FIN  = 6'b101000;
  localparam logic [5:0] JF   = 6'b001010;
  localparam logic [5:0] DH   = 6'b110010;
`ifdef PAUSE_CTRL_FWD_EN
  localparam logic [5:0] RAW = IDLE;
`else
  localparam logic [5:0] RAW = DH;
`endif

  always #5 clk = ~clk;

  pause_ctrl #(.WAIT_CYC(2)) u_dut2 (
    .clk_50MHz(clk), .rst(rst),
    .id_REGA_ADDR(id_a), .id_REGA_use(id_a_use),
    .id_REGB_ADDR(id_b), .id_REGB_use(id_b_use),
    .ie_WB_en(ie_wb_en), .ie_WB_ADDR(ie_wb_addr),
    .ie_RAM_en(ie_ram_en), .ie_RAM_op(ie_ram_op),
    .mem_WB_en(mem_wb_en), .mem_WB_ADDR(mem_wb_addr),
    .mem_RAM_en(mem_ram_en), .mem_RAM_ADDR(mem_ram_addr),
    .jump_en(jump_en),
    .pc_PAUSE(pc2), .if_PAUSE(ifp2), .if_FLUSH(iff2), .ie_PAUSE(iep2),
    .jump_control_ie_PAUSE(jc2), .em_PAUSE(em2)
  );

  pause_ctrl #(.WAIT_CYC(3)) u_dut3 (
    .clk_50MHz(clk), .rst(rst),
    .id_REGA_ADDR(id_a), .id_REGA_use(id_a_use),
    .id_REGB_ADDR(id_b), .id_REGB_use(id_b_use),
    .ie_WB_en(ie_wb_en), .ie_WB_ADDR(ie_wb_addr),
    .ie_RAM_en(ie_ram_en), .ie_RAM_op(ie_ram_op),
    .mem_WB_en(mem_wb_en), .mem_WB_ADDR(mem_wb_addr),
    .mem_RAM_en(mem_ram_en), .mem_RAM_ADDR(mem_ram_addr),
    .jump_en(jump_en),
    .pc_PAUSE(pc3), .if_PAUSE(ifp3), .if_FLUSH(iff3), .ie_PAUSE(iep3),
    .jump_control_ie_PAUSE(jc3), .em_PAUSE(em3)
  );

  // Monitor: outputs are combinational, so every cycle's expectations are checked mid-cycle.
  always @(negedge clk) begin
    sb_t        e;
    logic [5:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.dut3 ? {pc3, ifp3, iff3, iep3, jc3, em3}
                   : {pc2, ifp2, iff2, iep2, jc2, em2};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s (WAIT_CYC=%0d): got %b expected %b {pc,if_p,if_f,ie_p,jc,em}",
                 e.name, e.dut3 ? 3 : 2, act, e.exp);
      end
    end
  end

  task automatic clr();
    id_a = '0; id_b = '0; ie_wb_addr = '0; mem_wb_addr = '0;
    id_a_use = 1'b0; id_b_use = 1'b0; ie_wb_en = 1'b0; ie_ram_en = 1'b0;
    ie_ram_op = 1'b1; mem_wb_en = 1'b0; mem_ram_en = 1'b0; jump_en = 1'b0;
    mem_ram_addr = '0;
  endtask

  task automatic load_use_r3();
    ie_ram_en = 1'b1; ie_ram_op = 1'b0; ie_wb_en = 1'b1; ie_wb_addr = 4'd3;
    id_a_use = 1'b1; id_a = 4'd3;
  endtask

  task automatic step(input string nm, input logic [5:0] e2, input logic [5:0] e3);
    sb_t e;
    e.exp = e2; e.dut3 = 1'b0; e.name = nm; sb.push_back(e);
    e.exp = e3; e.dut3 = 1'b1; sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr();
    #1;
    step("rst_idle", IDLE, IDLE);
    jump_en = 1'b1; load_use_r3(); mem_ram_en = 1'b1;
    step("rst_forces_zero", IDLE, IDLE);
    clr(); rst = 1'b1;
    step("run_idle", IDLE, IDLE);

    load_use_r3();
    step("load_use", DH, DH);
    clr();
    step("load_use_done", IDLE, IDLE);
    ie_ram_en = 1'b1; ie_ram_op = 1'b0; ie_wb_en = 1'b1; ie_wb_addr = 4'd3;
    id_b = 4'd3; id_b_use = 1'b0; id_a_use = 1'b1; id_a = 4'd4;
    step("use_qualifier", IDLE, IDLE);
    clr();
    ie_wb_en = 1'b1; ie_wb_addr = 4'd5; id_b_use = 1'b1; id_b = 4'd5;
    step("alu_raw_b", RAW, RAW);
    clr();
    mem_wb_en = 1'b1; mem_wb_addr = 4'd7; id_a_use = 1'b1; id_a = 4'd7;
    step("mem_raw_a", RAW, RAW);
    clr();

    jump_en = 1'b1;
    step("jump_alone", JF, JF);
    load_use_r3();
    step("jump_over_hazard", JF, JF);
    clr();
    step("jump_done", IDLE, IDLE);
    mem_ram_en = 1'b1; mem_ram_addr = 16'h8000;
    step("iram_limit_8000", IDLE, IDLE);
    clr();

    mem_ram_en = 1'b1; mem_ram_addr = 16'h4000;
    step("stall_c1", HOLD, HOLD);
    clr(); load_use_r3();
    step("stall_c2", FIN, HOLD);
    clr();
    step("stall_c3", IDLE, FIN);
    step("stall_c4", IDLE, IDLE);

    mem_ram_en = 1'b1; mem_ram_addr = 16'h0100; jump_en = 1'b1;
    step("jstall_c1", HOLD, HOLD);
    mem_ram_en = 1'b0;
    step("jstall_c2", JF, HOLD);
    step("jstall_c3", JF, JF);
    jump_en = 1'b0;
    step("jstall_c4", IDLE, IDLE);

    mem_ram_en = 1'b1; mem_ram_addr = 16'h0000;
    step("rstw_c1", HOLD, HOLD);
    clr(); rst = 1'b0;
    step("rstw_in_reset", IDLE, IDLE);
    rst = 1'b1; jump_en = 1'b1;
    step("rstw_back_in_run", JF, JF);
    jump_en = 1'b0;
    step("rstw_idle", IDLE, IDLE);

    mem_ram_en = 1'b1; mem_ram_addr = 16'h7FFF;
    step("iram_7fff_c1", HOLD, HOLD);
    clr();
    step("iram_7fff_c2", FIN, HOLD);
    step("iram_7fff_c3", IDLE, FIN);
    step("iram_7fff_c4", IDLE, IDLE);
    mem_ram_en = 1'b0; mem_ram_addr = 16'h0000;
    step("ram_en_off", IDLE, IDLE);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
